// File: rtl/cpu_pkg.sv
// Shared core definitions: fetch FSM states, datapath widths and the default reset vector.
package cpu_pkg;

    localparam int unsigned PC_W    = 30;
    localparam int unsigned INSTR_W = 32;

    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = '0;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        VALID = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_if.sv
// Instruction-memory request/response port between the fetch unit and memory.
interface pc_fetch_if;
    import cpu_pkg::*;

    logic               req;
    logic               ready;
    logic [PC_W-1:0]    addr;
    logic               rvalid;
    logic [INSTR_W-1:0] rdata;

    modport master (output req, addr, input ready, rvalid, rdata);
    modport slave  (input req, addr, output ready, rvalid, rdata);

endinterface

// File: rtl/pc_fetch.sv
// Fetch front end: owns the PC, fetches one instruction at a time and holds it until commit.
module pc_fetch
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               rst,
    pc_fetch_if.master         imem,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [PC_W-1:0]    cur_pc,
    output logic [PC_W-1:0]    link_pc,
    input  logic               commit,
    input  logic [PC_W-1:0]    next_pc,
    output logic [31:0]        fetch_cnt
);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc;
    logic            capture;
    logic            retire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= BOOT;
            pc        <= RESET_PC;
            instr     <= '0;
            fetch_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                instr <= imem.rdata;
            end
            if (retire) begin
                pc        <= next_pc;
                fetch_cnt <= fetch_cnt + 32'd1;
            end
        end
    end

    // Strobes are qualified by state only, so stray rvalid/commit elsewhere are ignored.
    always_comb begin
        state_d     = state_q;
        capture     = 1'b0;
        retire      = 1'b0;
        imem.req    = 1'b0;
        instr_valid = 1'b0;
        case (state_q)
            BOOT: state_d = REQ;
            REQ: begin
                imem.req = 1'b1;
                if (imem.ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem.rvalid) begin
                    capture = 1'b1;
                    state_d = VALID;
                end
            end
            VALID: begin
                instr_valid = 1'b1;
                if (commit) begin
                    retire  = 1'b1;
                    state_d = REQ;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    assign imem.addr = pc;
    assign cur_pc    = pc;
    assign link_pc   = pc + PC_W'(1);

endmodule

// File: tb/tb_pc_fetch.sv
// Randomized and directed checks of pc_fetch against a transaction-level fetch model.
module tb_pc_fetch;
    import cpu_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic [PC_W-1:0]    cur_pc;
    logic [PC_W-1:0]    link_pc;
    logic               commit;
    logic [PC_W-1:0]    next_pc;
    logic [31:0]        fetch_cnt;

    pc_fetch_if imem ();

    pc_fetch #(.RESET_PC(30'd0)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (imem),
        .instr       (instr),
        .instr_valid (instr_valid),
        .cur_pc      (cur_pc),
        .link_pc     (link_pc),
        .commit      (commit),
        .next_pc     (next_pc),
        .fetch_cnt   (fetch_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Transaction view of the fetch unit: which part of a fetch is outstanding.
    bit               booting, want_req, in_flight, holding;
    logic [PC_W-1:0]  m_pc;
    logic [31:0]      m_instr;
    logic [31:0]      m_cnt;
    bit               model_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit rdy, input bit rv,
                              input logic [31:0] rd, input bit cm, input logic [PC_W-1:0] np);
        if (r) begin
            booting = 1; want_req = 0; in_flight = 0; holding = 0;
            m_pc = 30'd0; m_instr = '0; m_cnt = '0;
        end else if (booting) begin
            booting = 0; want_req = 1;
        end else if (want_req) begin
            if (rdy) begin want_req = 0; in_flight = 1; end
        end else if (in_flight) begin
            if (rv) begin m_instr = rd; in_flight = 0; holding = 1; end
        end else if (holding) begin
            if (cm) begin m_pc = np; m_cnt = m_cnt + 1; holding = 0; want_req = 1; end
        end
    endtask

    // Compare process: every cycle, shortly after the active edge.
    always @(posedge clk) begin
        #1;
        if (model_on) begin
            chk("imem_req",    {31'd0, imem.req},    {31'd0, want_req});
            chk("imem_addr",   {2'b0, imem.addr},    {2'b0, m_pc});
            chk("instr",       instr,                m_instr);
            chk("instr_valid", {31'd0, instr_valid}, {31'd0, holding});
            chk("cur_pc",      {2'b0, cur_pc},       {2'b0, m_pc});
            chk("link_pc",     {2'b0, link_pc},      {2'b0, m_pc + 30'd1});
            chk("fetch_cnt",   fetch_cnt,            m_cnt);
        end
    end

    task automatic tick(input bit r, input bit rdy, input bit rv,
                        input logic [31:0] rd, input bit cm, input logic [PC_W-1:0] np);
        rst = r; imem.ready = rdy; imem.rvalid = rv; imem.rdata = rd;
        commit = cm; next_pc = np;
        model_step(r, rdy, rv, rd, cm, np);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; imem.ready = 1'b0; imem.rvalid = 1'b0; imem.rdata = '0;
        commit = 1'b0; next_pc = '0;
        @(negedge clk);
        tick(1, 0, 0, 0, 0, 0);
        model_on = 1'b1;
        tick(1, 0, 0, 0, 0, 0);
        chk("rst_req",     {31'd0, imem.req}, 32'd0);
        chk("rst_addr",    {2'b0, imem.addr}, 32'd0);
        chk("rst_instr",   instr, 32'd0);
        chk("rst_valid",   {31'd0, instr_valid}, 32'd0);
        chk("rst_link",    {2'b0, link_pc}, 32'd1);
        chk("rst_cnt",     fetch_cnt, 32'd0);

        // Reset fetch: cycle 2 request, cycle 4 valid
        tick(0, 1, 0, 0, 0, 0);
        chk("boot_req_c2",  {31'd0, imem.req}, 32'd1);
        chk("boot_addr_c2", {2'b0, imem.addr}, 32'd0);
        tick(0, 1, 1, 32'hDEAD_0001, 0, 0);            // rvalid in accept cycle: dropped
        tick(0, 1, 1, 32'h2008_0005, 0, 0);
        chk("boot_valid_c4", {31'd0, instr_valid}, 32'd1);
        chk("boot_instr_c4", instr, 32'h2008_0005);
        chk("boot_pc_c4",    {2'b0, cur_pc}, 32'd0);
        chk("boot_link_c4",  {2'b0, link_pc}, 32'd1);

        // Commit redirect
        tick(0, 0, 0, 0, 1, 30'h40);
        chk("redir_pc",    {2'b0, cur_pc}, 32'h40);
        chk("redir_valid", {31'd0, instr_valid}, 32'd0);
        chk("redir_req",   {31'd0, imem.req}, 32'd1);
        chk("redir_addr",  {2'b0, imem.addr}, 32'h40);
        chk("redir_cnt",   fetch_cnt, 32'd1);

        // Backpressure with spurious rvalid/commit in REQ
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 1, 32'hBAD0_0000 + i, 1, 30'h123);
            chk("bp_req",  {31'd0, imem.req}, 32'd1);
            chk("bp_addr", {2'b0, imem.addr}, 32'h40);
        end
        tick(0, 1, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 1, 30'h77);                    // commit in WAIT ignored
        tick(0, 0, 0, 0, 1, 30'h77);
        chk("wait_pc",  {2'b0, cur_pc}, 32'h40);
        chk("wait_cnt", fetch_cnt, 32'd1);
        chk("wait_nov", {31'd0, instr_valid}, 32'd0);
        tick(0, 0, 1, 32'hCAFE_0011, 0, 0);
        chk("bp_instr", instr, 32'hCAFE_0011);
        tick(0, 0, 1, 32'hCAFE_0022, 0, 0);             // rvalid in VALID ignored
        chk("valid_hold_instr", instr, 32'hCAFE_0011);

        // PC wrap
        tick(0, 1, 0, 0, 1, 30'h3FFF_FFFF);
        tick(0, 1, 0, 0, 0, 0);
        tick(0, 1, 1, 32'h1234_5678, 0, 0);
        chk("wrap_pc",   {2'b0, cur_pc}, 32'h3FFF_FFFF);
        chk("wrap_link", {2'b0, link_pc}, 32'd0);

        // Counter wrap
        force dut.fetch_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_cnt;
        m_cnt = 32'hFFFF_FFFF;
        tick(0, 1, 0, 0, 1, 30'h8);
        chk("cnt_wrap", fetch_cnt, 32'd0);

        // Mid-fetch reset
        tick(0, 1, 0, 0, 0, 0);                         // accepted, now WAIT
        tick(1, 1, 0, 0, 0, 0);
        chk("mrst_req",   {31'd0, imem.req}, 32'd0);
        chk("mrst_instr", instr, 32'd0);
        tick(0, 0, 1, 32'hFEED_BEEF, 0, 0);
        chk("mrst_instr2", instr, 32'd0);
        chk("mrst_req2",   {31'd0, imem.req}, 32'd1);
        chk("mrst_addr2",  {2'b0, imem.addr}, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit r, rdy, rv, cm;
            logic [PC_W-1:0] np;
            r   = ($urandom % 64) == 0;
            rdy = $urandom % 2;
            rv  = in_flight ? (($urandom % 3) == 0) : (($urandom % 5) == 0);
            cm  = ($urandom % 3) == 0;
            np  = (($urandom % 8) == 0) ? 30'h3FFF_FFFF : PC_W'($urandom);
            tick(r, rdy, rv, $urandom, cm, np);
        end

        model_on = 1'b0;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Instruction-fetch front end for the single-cycle core. It owns the architectural program counter (word address, 30 bits), fetches the instruction at that address over a request/response instruction-memory port, and presents it with `cur_pc` and `link_pc` to the datapath. It then waits for the datapath to commit that instruction together with the computed next PC. It sits upstream of the next-PC logic and consumes that logic's `next_pc` output, closing the PC loop.

## Interface
Parameters:
- `RESET_PC`, 30'd0: word address fetched first after reset.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `imem_req`  out  1  instruction-memory request valid.
- `imem_ready`  in  1  memory accepts the request this cycle.
- `imem_addr`  out  30  word address of the request.
- `imem_rvalid`  in  1  response data valid.
- `imem_rdata`  in  32  response instruction word.
- `instr`  out  32  current instruction, registered.
- `instr_valid`  out  1  `instr`, `cur_pc` and `link_pc` are valid for the datapath.
- `cur_pc`  out  30  word address of `instr`.
- `link_pc`  out  30  `cur_pc + 1`, the return address for jal/jalr.
- `commit`  in  1  datapath retires `instr` this cycle.
- `next_pc`  in  30  PC of the following instruction; sampled only when `commit` is accepted.
- `fetch_cnt`  out  32  number of instructions committed since reset.

## Operation
- FSM has four states: BOOT, REQ, WAIT, VALID.
- **BOOT** (entered by reset): `imem_req`=0. Next cycle → REQ.
- **REQ**: `imem_req`=1 and `imem_addr`=`pc`. When `imem_ready`=1 → WAIT. `imem_addr` stays stable while `imem_ready`=0.
- **WAIT**: `imem_req`=0. When `imem_rvalid`=1:
  - `instr` ← `imem_rdata`.
  - → VALID.
- **VALID**: `instr_valid`=1. When `commit`=1:
  - `pc` ← `next_pc`.
  - `fetch_cnt` ← `fetch_cnt + 1`.
  - → REQ.
- `commit` in any state other than VALID is ignored: no PC change, no count.
- `imem_rvalid` outside WAIT is ignored. This includes the cycle in which the request is accepted.
- `link_pc = cur_pc + 1` is modulo 2^30. At `cur_pc`=30'h3FFFFFFF, `link_pc` is 0.
- `next_pc` is taken verbatim. There is no alignment check, because the address is already a word address.
- `fetch_cnt` wraps from 32'hFFFFFFFF to 0.
- `cur_pc` equals the internal `pc`. It changes only on an accepted commit or on reset.

## Timing
- Reset values:
  - state BOOT
  - `imem_req`=0
  - `imem_addr`=`RESET_PC`
  - `instr`=0
  - `instr_valid`=0
  - `cur_pc`=`RESET_PC`
  - `link_pc`=`RESET_PC+1`
  - `fetch_cnt`=0
- All outputs are registered or decoded from the state register only. There is no combinational path from any input to any output.
- Best-case loop is 3 cycles per instruction: REQ accepted, rvalid on the next cycle, VALID with immediate commit.
- After reset is deasserted: `imem_req` is first high in cycle 2, and `instr_valid` is first high in cycle 4 at the earliest.
- `instr_valid` drops in the cycle after commit. `cur_pc` shows `next_pc` from that same cycle.
- Reset asserted in any state:
  - Next state is BOOT and all registers take their reset values.
  - A response still in flight from memory arrives outside WAIT and is dropped.
  - The memory shares `rst` and must discard outstanding requests.
- Backpressure: `imem_ready`=0 holds REQ indefinitely, with `imem_req` and `imem_addr` constant. A missing `imem_rvalid` holds WAIT indefinitely.

## Structure
- Shared package `cpu_pkg` holds:
  - the fetch-state enum (BOOT/REQ/WAIT/VALID)
  - the `PC_W`=30 and `INSTR_W`=32 constants
  - the default reset vector
- The block is a single module with no sub-modules. The PC, instruction register, counter and FSM are all local.

## Test plan
- **Reset fetch:** release `rst`; memory has `imem_ready`=1 and returns 32'h2008_0005 one cycle after accept. Required: `imem_addr`=0 in cycle 2; `instr_valid`=1 with `instr`=32'h2008_0005, `cur_pc`=0 and `link_pc`=1 in cycle 4.
- **Commit redirect:** in VALID, pulse `commit` with `next_pc`=30'h40. Required: next cycle `cur_pc`=30'h40, `instr_valid`=0, `imem_req`=1 with `imem_addr`=30'h40, `fetch_cnt`=1.
- **Backpressure:** hold `imem_ready`=0 for 5 cycles in REQ, then give rvalid latency 3. Required: `imem_req` and `imem_addr` stable throughout; single capture of the returned data; no early `instr_valid`.
- **Spurious inputs:** `commit` during WAIT and `imem_rvalid` during REQ/VALID. Required: `cur_pc`, `instr` and `fetch_cnt` are unchanged.
- **Wrap:** commit with `next_pc`=30'h3FFFFFFF. Required: `link_pc`=0 once the instruction is valid. Separately, preload `fetch_cnt` via 2^32 commits, or force the counter to 32'hFFFFFFFF, then commit once. Required: `fetch_cnt`=0.
- **Mid-fetch reset:** assert `rst` in WAIT, then deliver `imem_rvalid` in the cycle after reset. Required: data is dropped; BOOT then REQ at `RESET_PC`; `instr`=0.
